// File: rtl/tcdm_stream_pkg.sv
// Shared types and sizing helpers for the TCDM read streamer.
//   state_e   : streamer FSM states (IDLE, ISSUE, DRAIN)
//   desc_t    : strided read descriptor (base, stride, len) at default widths
//   CntWidth  : counter width for the default response buffer depth
//   cnt_width : counter width able to hold 0..depth inclusive
package tcdm_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned DefaultDataWidth = 64;
   localparam int unsigned DefaultAddrWidth = 12;
   localparam int unsigned DefaultLenWidth  = 16;
   localparam int unsigned DefaultFifoDepth = 4;

   localparam int unsigned CntWidth = $clog2(DefaultFifoDepth) + 1;

   typedef struct packed {
      logic [DefaultAddrWidth-1:0] base;
      logic [DefaultAddrWidth-1:0] stride;
      logic [DefaultLenWidth-1:0]  len;
   } desc_t;

   // One extra bit so a counter can represent "depth" itself (full).
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tcdm_rsp_fifo.sv
// Response buffer for the TCDM read streamer: synchronous FIFO, registered
// head, no fall-through (a word pushed on edge N is visible after edge N).
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset (flushes contents)
//   push_i, data_i   : write strobe and data (ignored when full)
//   pop_i            : read strobe (ignored when empty)
//   data_o           : current head entry
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries (0..Depth)
module tcdm_rsp_fifo
   import tcdm_stream_pkg::*;
#(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        push_i,
   input  logic [Width-1:0]            data_i,
   input  logic                        pop_i,
   output logic [Width-1:0]            data_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [cnt_width(Depth)-1:0] count_o
);

   localparam int unsigned PtrWidth = $clog2(Depth);
   localparam int unsigned CntW     = cnt_width(Depth);

   logic [Width-1:0]    mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [CntW-1:0]     count_q;
   logic                push_ok;
   logic                pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Depth is a power of two, so the pointers wrap naturally.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
         end
         count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

endmodule

// File: rtl/tcdm_read_streamer.sv
// Strided TCDM read streamer: accepts a descriptor (base, stride, len), issues
// one narrow read per element on a TCDM port, buffers the in-order responses
// in a credit-protected FIFO and streams them out via valid/ready.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o     : descriptor handshake (ready only in IDLE)
//   cfg_base_i/stride_i/len_i   : descriptor fields (byte address, byte stride, count)
//   tcdm_req_*_o                : TCDM request channel (read-only, constant fields tied)
//   tcdm_rsp_q_ready_i          : request grant
//   tcdm_rsp_p_valid_i/data_i   : response (no backpressure)
//   data_o/data_valid_o/data_ready_i : output element stream
//   busy_o                      : FSM not in IDLE
//   done_o                      : one-cycle pulse when a descriptor completes
// Optional build macro TCDM_READ_STREAMER_PERF_EN adds stall_cycles_o, a
// saturating count of cycles a request waited for grant, cleared at accept.
module tcdm_read_streamer
   import tcdm_stream_pkg::*;
#(
   parameter int unsigned NarrowDataWidth = DefaultDataWidth,
   parameter int unsigned TCDMAddrWidth   = DefaultAddrWidth,
   parameter int unsigned LenWidth        = DefaultLenWidth,
   parameter int unsigned FifoDepth       = DefaultFifoDepth
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         cfg_valid_i,
   output logic                         cfg_ready_o,
   input  logic [TCDMAddrWidth-1:0]     cfg_base_i,
   input  logic [TCDMAddrWidth-1:0]     cfg_stride_i,
   input  logic [LenWidth-1:0]          cfg_len_i,
   output logic                         tcdm_req_write_o,
   output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
   output logic [3:0]                   tcdm_req_amo_o,
   output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
   output logic [4:0]                   tcdm_req_user_core_id_o,
   output logic                         tcdm_req_user_is_core_o,
   output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
   output logic                         tcdm_req_q_valid_o,
   input  logic                         tcdm_rsp_q_ready_i,
   input  logic                         tcdm_rsp_p_valid_i,
   input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
   output logic [NarrowDataWidth-1:0]   data_o,
   output logic                         data_valid_o,
   input  logic                         data_ready_i,
   output logic                         busy_o,
   output logic                         done_o
`ifdef TCDM_READ_STREAMER_PERF_EN
   ,
   output logic [31:0]                  stall_cycles_o
`endif
);

   localparam int unsigned CntW      = cnt_width(FifoDepth);
   localparam int unsigned SumW      = CntW + 1;
   localparam int unsigned StrbWidth = NarrowDataWidth / 8;

   state_e                   state_q;
   logic [TCDMAddrWidth-1:0] addr_q;
   logic [TCDMAddrWidth-1:0] stride_q;
   logic [LenWidth-1:0]      remaining_q;
   logic [CntW-1:0]          inflight_q;
   logic                     done_q;

   logic [CntW-1:0]          fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;

   logic                     cfg_fire;
   logic                     credit_ok;
   logic                     req_valid;
   logic                     grant;
   logic                     rsp_push;
   logic                     rsp_pop;

   // Constant request fields: read-only, full-word accesses.
   assign tcdm_req_write_o        = 1'b0;
   assign tcdm_req_amo_o          = 4'd0;
   assign tcdm_req_data_o         = '0;
   assign tcdm_req_user_core_id_o = 5'd0;
   assign tcdm_req_user_is_core_o = 1'b0;
   assign tcdm_req_strb_o         = {StrbWidth{1'b1}};

   assign cfg_ready_o = (state_q == IDLE);
   assign cfg_fire    = cfg_valid_i && cfg_ready_o;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;

   // Every outstanding request already owns a FIFO slot, so responses never overflow.
   // Credits only grow while a request waits, which keeps valid/address stable until grant.
   assign credit_ok = (SumW'(inflight_q) + SumW'(fifo_count)) < SumW'(FifoDepth);
   assign req_valid = (state_q == ISSUE) && credit_ok;
   assign grant     = req_valid && tcdm_rsp_q_ready_i;

   assign tcdm_req_q_valid_o = req_valid;
   assign tcdm_req_addr_o    = addr_q;

   // Stray responses with nothing outstanding (e.g. after a reset) are dropped.
   assign rsp_push     = tcdm_rsp_p_valid_i && (inflight_q != '0) && !fifo_full;
   assign data_valid_o = !fifo_empty;
   assign rsp_pop      = data_valid_o && data_ready_i;

   tcdm_rsp_fifo #(
      .Width (NarrowDataWidth),
      .Depth (FifoDepth)
   ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rsp_push),
      .data_i  (tcdm_rsp_data_i),
      .pop_i   (rsp_pop),
      .data_o  (data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Control FSM, address generator and outstanding-request counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
         inflight_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= inflight_q + CntW'(grant) - CntW'(rsp_push);
         case (state_q)
            IDLE: begin
               if (cfg_fire) begin
                  addr_q      <= cfg_base_i;
                  stride_q    <= cfg_stride_i;
                  remaining_q <= cfg_len_i;
                  if (cfg_len_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (grant) begin
                  addr_q      <= addr_q + stride_q;
                  remaining_q <= remaining_q - LenWidth'(1);
                  if (remaining_q == LenWidth'(1)) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Empty FIFO with nothing outstanding means the last element was consumed.
               if ((inflight_q == '0) && fifo_empty) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef TCDM_READ_STREAMER_PERF_EN
   logic [31:0] stall_q;

   // Cycles a request waited for grant, saturating.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (cfg_fire) begin
         stall_q <= '0;
      end else if (req_valid && !tcdm_rsp_q_ready_i && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_tcdm_read_streamer.sv
// Scoreboard bench for tcdm_read_streamer: a TCDM memory responder with
// random grant/latency, a random consumer, and a monitor comparing requested
// addresses and streamed words against a descriptor-level reference model.
module tb_tcdm_read_streamer;
   import tcdm_stream_pkg::*;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 12;
   localparam int unsigned LW = 16;
   localparam int unsigned FD = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          cfg_valid_i = 1'b0;
   logic          cfg_ready_o;
   logic [AW-1:0] cfg_base_i = '0;
   logic [AW-1:0] cfg_stride_i = '0;
   logic [LW-1:0] cfg_len_i = '0;
   logic          tcdm_req_write_o;
   logic [AW-1:0] tcdm_req_addr_o;
   logic [3:0]    tcdm_req_amo_o;
   logic [DW-1:0] tcdm_req_data_o;
   logic [4:0]    tcdm_req_user_core_id_o;
   logic          tcdm_req_user_is_core_o;
   logic [DW/8-1:0] tcdm_req_strb_o;
   logic          tcdm_req_q_valid_o;
   logic          tcdm_rsp_q_ready_i = 1'b0;
   logic          tcdm_rsp_p_valid_i = 1'b0;
   logic [DW-1:0] tcdm_rsp_data_i = '0;
   logic [DW-1:0] data_o;
   logic          data_valid_o;
   logic          data_ready_i = 1'b0;
   logic          busy_o;
   logic          done_o;
`ifdef TCDM_READ_STREAMER_PERF_EN
   logic [31:0]   stall_cycles_o;
`endif

   tcdm_read_streamer #(
      .NarrowDataWidth (DW),
      .TCDMAddrWidth   (AW),
      .LenWidth        (LW),
      .FifoDepth       (FD)
   ) dut (
      .clk_i                   (clk),
      .rst_i                   (rst_i),
      .cfg_valid_i             (cfg_valid_i),
      .cfg_ready_o             (cfg_ready_o),
      .cfg_base_i              (cfg_base_i),
      .cfg_stride_i            (cfg_stride_i),
      .cfg_len_i               (cfg_len_i),
      .tcdm_req_write_o        (tcdm_req_write_o),
      .tcdm_req_addr_o         (tcdm_req_addr_o),
      .tcdm_req_amo_o          (tcdm_req_amo_o),
      .tcdm_req_data_o         (tcdm_req_data_o),
      .tcdm_req_user_core_id_o (tcdm_req_user_core_id_o),
      .tcdm_req_user_is_core_o (tcdm_req_user_is_core_o),
      .tcdm_req_strb_o         (tcdm_req_strb_o),
      .tcdm_req_q_valid_o      (tcdm_req_q_valid_o),
      .tcdm_rsp_q_ready_i      (tcdm_rsp_q_ready_i),
      .tcdm_rsp_p_valid_i      (tcdm_rsp_p_valid_i),
      .tcdm_rsp_data_i         (tcdm_rsp_data_i),
      .data_o                  (data_o),
      .data_valid_o            (data_valid_o),
      .data_ready_i            (data_ready_i),
      .busy_o                  (busy_o),
      .done_o                  (done_o)
`ifdef TCDM_READ_STREAMER_PERF_EN
      ,
      .stall_cycles_o          (stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory contents as seen by the responder: a fixed function of the address.
   function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
      return {a, 20'hC0DE5, 32'(a) * 32'h9E37_79B9 + 32'h1234_5678};
   endfunction

   // Scoreboard queues, filled from descriptors, drained by the monitor.
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];

   typedef struct {
      int unsigned   due;
      logic [DW-1:0] data;
   } rsp_t;
   rsp_t pend_q[$];

   // Knobs set by the main sequence.
   int unsigned q_prob = 100;
   int unsigned c_prob = 100;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int unsigned hold_n = 0;
   int unsigned grant_budget = 32'hFFFF_FFFF;
   bit          cons_hold = 1'b0;

   // Observations.
   int unsigned grant_cyc_q[$];
   int unsigned pvalid_cnt = 0;
   int unsigned done_count = 0;
   int unsigned done_cyc = 0;
   int unsigned last_pop_cyc = 0;
   int unsigned hs_cyc = 0;
   int unsigned d0 = 0;
   int unsigned cur_len = 0;

   // TCDM responder: random grant, in-order responses after a random latency.
   initial begin
      int unsigned last_due;
      int unsigned due;
      last_due = 0;
      forever begin
         @(negedge clk);
         if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            tcdm_rsp_p_valid_i = 1'b1;
            tcdm_rsp_data_i    = pend_q[0].data;
            void'(pend_q.pop_front());
            pvalid_cnt++;
         end else begin
            tcdm_rsp_p_valid_i = 1'b0;
            tcdm_rsp_data_i    = {$urandom, $urandom};
         end
         if (tcdm_req_q_valid_o && hold_n > 0) begin
            tcdm_rsp_q_ready_i = 1'b0;
            hold_n--;
         end else begin
            tcdm_rsp_q_ready_i = (grant_budget > 0) && ($urandom_range(0, 99) < q_prob);
         end
         if (tcdm_req_q_valid_o && tcdm_rsp_q_ready_i) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{due, mem_word(tcdm_req_addr_o)});
            grant_budget--;
            grant_cyc_q.push_back(cyc);
         end
      end
   end

   // Consumer.
   initial begin
      forever begin
         @(negedge clk);
         data_ready_i = !cons_hold && ($urandom_range(0, 99) < c_prob);
      end
   end

   // Monitor: request addresses, request stability, stream data, done pulses.
   initial begin
      bit            prev_wait;
      logic [AW-1:0] prev_addr;
      prev_wait = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst_i) begin
            prev_wait = 1'b0;
         end else begin
            if (prev_wait) begin
               check("req_hold_valid", 64'(tcdm_req_q_valid_o), 64'd1);
               check("req_hold_addr", 64'(tcdm_req_addr_o), 64'(prev_addr));
            end
            if (tcdm_req_q_valid_o && tcdm_rsp_q_ready_i) begin
               if (exp_addr_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
               else check("req_addr", 64'(tcdm_req_addr_o), 64'(exp_addr_q.pop_front()));
            end
            prev_wait = tcdm_req_q_valid_o && !tcdm_rsp_q_ready_i;
            prev_addr = tcdm_req_addr_o;
            if (data_valid_o && data_ready_i) begin
               if (exp_data_q.size() == 0) check("data_unexpected", 64'd1, 64'd0);
               else check("data", data_o, exp_data_q.pop_front());
               last_pop_cyc = cyc;
            end
            if (done_o) begin
               done_count++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic start_desc(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [LW-1:0] len);
      int unsigned n;
      logic [AW-1:0] a;
      n = 0;
      @(negedge clk);
      while (!cfg_ready_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready_o) check("cfg_ready_timeout", 64'd0, 64'd1);
      for (int unsigned i = 0; i < 32'(len); i++) begin
         a = AW'(32'(base) + i * 32'(stride));
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem_word(a));
      end
      grant_cyc_q.delete();
      cur_len      = 32'(len);
      d0           = done_count;
      cfg_valid_i  = 1'b1;
      cfg_base_i   = base;
      cfg_stride_i = stride;
      cfg_len_i    = len;
      @(negedge clk);
      hs_cyc       = cyc;
      cfg_valid_i  = 1'b0;
      cfg_base_i   = AW'($urandom);
      cfg_stride_i = AW'($urandom);
      cfg_len_i    = LW'($urandom);
   endtask

   task automatic finish_desc();
      int unsigned n;
      n = 0;
      while (done_count == d0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done_count != d0), 64'd1);
      repeat (3) @(negedge clk);
      check("done_once", 64'(done_count - d0), 64'd1);
      check("addr_sb_empty", 64'(exp_addr_q.size()), 64'd0);
      check("data_sb_empty", 64'(exp_data_q.size()), 64'd0);
      check("grant_count", 64'(grant_cyc_q.size()), 64'(cur_len));
      check("busy_after_done", 64'(busy_o), 64'd0);
      if (cur_len != 0) check("done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'd2);
   endtask

   initial begin
      int unsigned n;
      int unsigned p0;
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      int unsigned p0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_cfg_ready", 64'(cfg_ready_o), 64'd1);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_q_valid", 64'(tcdm_req_q_valid_o), 64'd0);
      check("rst_data_valid", 64'(data_valid_o), 64'd0);
      check("rst_addr", 64'(tcdm_req_addr_o), 64'd0);
      check("rst_data", data_o, 64'd0);
      check("tie_write", 64'(tcdm_req_write_o), 64'd0);
      check("tie_amo", 64'(tcdm_req_amo_o), 64'd0);
      check("tie_wdata", tcdm_req_data_o, 64'd0);
      check("tie_core_id", 64'(tcdm_req_user_core_id_o), 64'd0);
      check("tie_is_core", 64'(tcdm_req_user_is_core_o), 64'd0);
      check("tie_strb", 64'(tcdm_req_strb_o), 64'hFF);
      rst_i = 1'b0;

      // Full-rate stream: requests on consecutive cycles starting one cycle after accept.
      start_desc(12'h100, 12'h008, 16'd4);
      finish_desc();
      check("t1_first_req", 64'(grant_cyc_q[0]), 64'(hs_cyc));
      check("t1_req_span", 64'(grant_cyc_q[3] - grant_cyc_q[0]), 64'd3);
      check("t1_done_latency", 64'(done_cyc - hs_cyc), 64'd7);

      // Consumer stalled: only FifoDepth requests may be outstanding.
      cons_hold = 1'b1;
      start_desc(12'h100, 12'h008, 16'd8);
      repeat (10) @(negedge clk);
      check("t2_req_limit", 64'(grant_cyc_q.size()), 64'(FD));
      check("t2_q_valid_low", 64'(tcdm_req_q_valid_o), 64'd0);
      check("t2_data_valid", 64'(data_valid_o), 64'd1);
      check("t2_busy", 64'(busy_o), 64'd1);
      cons_hold = 1'b0;
      finish_desc();

      // Grant withheld for 3 cycles on the first request.
      hold_n = 3;
      start_desc(12'h100, 12'h008, 16'd4);
      finish_desc();
      check("t3_first_grant", 64'(grant_cyc_q[0]), 64'(hs_cyc + 3));
`ifdef TCDM_READ_STREAMER_PERF_EN
      check("t3_stall_cycles", 64'(stall_cycles_o), 64'd3);
`endif

      // Address wrap.
      start_desc(12'hFF8, 12'h010, 16'd3);
      finish_desc();

      // Zero-length descriptor.
      start_desc(12'h200, 12'h004, 16'd0);
      check("t5_cfg_ready", 64'(cfg_ready_o), 64'd1);
      check("t5_done_now", 64'(done_o), 64'd1);
      finish_desc();
      check("t5_done_cycle", 64'(done_cyc), 64'(hs_cyc));

      // Random descriptors under random grant, latency and backpressure.
      for (int k = 0; k < 8; k++) begin
         q_prob  = $urandom_range(40, 100);
         c_prob  = $urandom_range(30, 100);
         lat_min = $urandom_range(1, 2);
         lat_max = lat_min + $urandom_range(0, 3);
         start_desc(AW'($urandom), AW'($urandom), LW'($urandom_range(1, 12)));
         finish_desc();
      end

      // Reset with two requests in flight, followed by stray responses.
      q_prob = 100; c_prob = 100; lat_min = 10; lat_max = 10;
      grant_budget = 2;
      p0 = pvalid_cnt;
      start_desc(12'h300, 12'h008, 16'd8);
      n = 0;
      while (grant_cyc_q.size() < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t7_two_inflight", 64'(grant_cyc_q.size()), 64'd2);
      rst_i = 1'b1;
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      grant_budget = 32'hFFFF_FFFF;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check("t7_data_valid", 64'(data_valid_o), 64'd0);
         check("t7_busy", 64'(busy_o), 64'd0);
         check("t7_done", 64'(done_o), 64'd0);
      end
      check("t7_strays_sent", 64'(pvalid_cnt - p0), 64'd2);
      check("t7_no_done", 64'(done_count), 64'(d0));

      // Normal operation after the abandoned descriptor.
      lat_min = 1; lat_max = 2;
      start_desc(12'h040, 12'h004, 16'd5);
      finish_desc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
